hwpe_stream_sidech_packetizer: RTL and testbench



---
 rtl/hwpe_stream_sidech_packetizer_if.sv | 11 +
 rtl/hwpe_stream_sidech_packetizer.sv | 101 ++++++++++
 tb/tb_hwpe_stream_sidech_packetizer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_sidech_packetizer_if.sv
// hwpe_stream_intf_stream: valid/ready stream carrying data with byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    modport source (output valid, data, strb, input ready);
    modport sink (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_sidech_packetizer.sv
// hwpe_stream_sidech_packetizer: cuts a plain stream into packets of a programmed
// length and tags every beat with {pkt_id, last} through one registered output stage.
module hwpe_stream_sidech_packetizer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [LEN_WIDTH-1:0]   len_i,
    input  logic [ID_WIDTH-1:0]    id_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [LEN_WIDTH-1:0]   beat_cnt_o,
    hwpe_stream_intf_stream.sink   push_i,
    hwpe_stream_intf_stream.source pop_o,
    output logic [ID_WIDTH:0]      sidech_o
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                state_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [STRB_WIDTH-1:0] out_strb_q;
    logic [ID_WIDTH-1:0]   out_id_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  push_hs;
    logic                  pop_hs;
    logic                  is_last;

    // Accepting while the register drains keeps the stream at one beat per cycle.
    assign push_i.ready = (state_q == RUN) && (!out_valid_q || pop_o.ready);
    assign push_hs      = push_i.valid && push_i.ready;
    assign pop_hs       = out_valid_q && pop_o.ready;
    assign is_last      = cnt_q == len_q - LEN_WIDTH'(1);

    assign pop_o.valid = out_valid_q;
    assign pop_o.data  = out_valid_q ? out_data_q : '0;
    assign pop_o.strb  = out_valid_q ? out_strb_q : '0;
    assign sidech_o    = out_valid_q ? {out_id_q, out_last_q} : '0;
    assign busy_o      = state_q != IDLE;
    assign done_o      = done_q;
    assign beat_cnt_o  = cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_id_q    <= '0;
            id_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (push_hs) begin
                out_valid_q <= 1'b1;
                out_data_q  <= push_i.data;
                out_strb_q  <= push_i.strb;
                out_id_q    <= id_q;
                out_last_q  <= is_last;
                cnt_q       <= cnt_q + LEN_WIDTH'(1);
            end else if (pop_hs) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_i && len_i != '0) begin
                        len_q   <= len_i;
                        id_q    <= id_i;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else if (start_i) begin
                        done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (push_hs && is_last) state_q <= FLUSH;
                end
                FLUSH: begin
                    if (pop_hs) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hwpe_stream_sidech_packetizer.sv
// tb_hwpe_stream_sidech_packetizer: scoreboard bench; expected tagged beats are queued
// when a packet is started and popped by a monitor as the DUT emits them.
module tb_hwpe_stream_sidech_packetizer;
    typedef struct packed {
        logic [3:0]  id;
        logic        last;
        logic [31:0] data;
        logic [3:0]  strb;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, clear, start;
    logic [15:0] len;
    logic [3:0]  id;
    logic        busy, done;
    logic [15:0] beat_cnt;
    logic [4:0]  sidech;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_if ();

    hwpe_stream_sidech_packetizer #(.DATA_WIDTH(32), .LEN_WIDTH(16), .ID_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .len_i(len), .id_i(id),
        .busy_o(busy), .done_o(done), .beat_cnt_o(beat_cnt),
        .push_i(push_if), .pop_o(pop_if), .sidech_o(sidech)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          done_seen = 0;
    int          done_exp = 0;
    int          stall_cycles = 0;
    bit          mon_en = 0;
    bit          pop_rand = 0;
    logic        rdy_force = 1'b1;
    beat_t       exp_q[$];
    logic [35:0] pend_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    initial pop_if.ready = 1'b0;
    always @(posedge clk) begin
        #1;
        pop_if.ready = pop_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    bit prev_stall = 0;
    bit prev_rst = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (pop_if.valid) begin
                chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("beat", {pop_if.data, pop_if.strb, sidech},
                        {exp_q[0].data, exp_q[0].strb, exp_q[0].id, exp_q[0].last});
                    if (pop_if.ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("gating", {pop_if.data, pop_if.strb, sidech}, 64'd0);
            end
            if (!busy) chk("idle_ready", 64'(push_if.ready), 64'd0);
            if (pop_if.valid && !pop_if.ready) chk("full_ready", 64'(push_if.ready), 64'd0);
            if (prev_stall && !prev_rst) chk("hold_valid", 64'(pop_if.valid), 64'd1);
            prev_stall = pop_if.valid && !pop_if.ready;
            prev_rst   = rst || clear;
            if (done) done_seen++;
        end
    end

    task automatic start_pkt(input int l, input int i, input logic [31:0] base, input bit rnd);
        int w = 0;
        beat_t e;
        while (busy && w < 2000) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("start_idle", 64'(busy), 64'd0);
        start = 1'b1;
        len   = 16'(l);
        id    = 4'(i);
        for (int k = 0; k < l; k++) begin
            e.id   = 4'(i);
            e.last = (k == l - 1);
            e.data = rnd ? $urandom : base + 32'(k);
            e.strb = rnd ? 4'($urandom) : 4'hF;
            exp_q.push_back(e);
            pend_q.push_back({e.data, e.strb});
        end
        done_exp++;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps);
        logic [35:0] d;
        int w;
        for (int k = 0; k < n; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            d = pend_q.pop_front();
            push_if.valid = 1'b1;
            push_if.data  = d[35:4];
            push_if.strb  = d[3:0];
            w = 0;
            @(negedge clk);
            while (!push_if.ready && w < 500) begin
                stall_cycles++;
                w++;
                @(negedge clk);
            end
            if (w >= 500) begin
                $display("FAIL push_timeout: ready never rose");
                fails++;
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $fatal(1, "push handshake timeout");
            end
            @(posedge clk);
            #1;
            push_if.valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int l, output int n);
        n = 0;
        while (done_seen < done_exp && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_count", 64'(done_seen), 64'(done_exp));
        if (l != 0) chk("beat_cnt", 64'(beat_cnt), 64'(l));
        chk("busy_after", 64'(busy), 64'd0);
        chk("drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; clear = 1'b0; start = 1'b0; len = '0; id = '0;
        push_if.valid = 1'b1; push_if.data = 32'hDEAD_BEEF; push_if.strb = 4'hF;
        @(posedge clk);
        #1;
        mon_en = 1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", 64'(pop_if.valid), 64'd0);
            chk("rst_ready", 64'(push_if.ready), 64'd0);
            chk("rst_sidech", 64'(sidech), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_cnt", 64'(beat_cnt), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_if.valid = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;

        // basic packet: full rate, one cycle latency
        stall_cycles = 0;
        start_pkt(4, 5, 32'hA0, 0);
        feed(4, 0);
        wait_done(4, n);
        chk("basic_stalls", 64'(stall_cycles), 64'd0);
        chk("basic_done_lat", 64'(n), 64'd2);

        // backpressure on the first beat
        rdy_force = 1'b0;
        stall_cycles = 0;
        start_pkt(3, 6, 32'hA0, 0);
        fork
            feed(3, 0);
            begin
                repeat (4) @(posedge clk);
                #1;
                rdy_force = 1'b1;
            end
        join
        wait_done(3, n);
        chk("bp_stalls", 64'(stall_cycles), 64'd3);

        // zero length
        start_pkt(0, 9, 32'h0, 0);
        @(negedge clk);
        #1;
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_valid", 64'(pop_if.valid), 64'd0);
        @(negedge clk);
        #1;
        chk("zero_pulse", 64'(done), 64'd0);
        chk("zero_count", 64'(done_seen), 64'(done_exp));
        @(posedge clk);
        #1;

        // start while busy is ignored
        start_pkt(2, 1, 32'h10, 0);
        feed(1, 0);
        start = 1'b1; id = 4'd7; len = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_restart_cnt", 64'(beat_cnt), 64'd1);
        feed(1, 0);
        wait_done(2, n);
        repeat (2) begin
            @(negedge clk);
            chk("no_restart", 64'(busy), 64'd0);
        end
        @(posedge clk);
        #1;

        // clear mid-packet
        start_pkt(8, 3, 32'h20, 0);
        feed(3, 0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_q.delete();
        pend_q.delete();
        done_exp--;
        @(negedge clk);
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_valid", 64'(pop_if.valid), 64'd0);
        chk("clr_cnt", 64'(beat_cnt), 64'd0);
        @(posedge clk);
        #1;
        start_pkt(1, 2, 32'h55, 0);
        feed(1, 0);
        wait_done(1, n);

        // randomized packets with random backpressure and input gaps
        pop_rand = 1;
        for (int p = 0; p < 25; p++) begin
            int l;
            l = $urandom_range(1, 10);
            start_pkt(l, $urandom_range(0, 15), 32'h0, 1);
            feed(l, 1);
            wait_done(l, n);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
